// File: rtl/check_check.sv
// Registered "is this king attacked" evaluator for a 64-square, 4-bit-per-square board.
// Optional pawn attacks are enabled by defining CHECK_CHECK_PAWN_ATTACK_EN.
module check_check (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] bigBoard,
    input  logic [5:0]   currentPosition,
    output logic         inCheck
);

    localparam logic [2:0] T_EMPTY  = 3'b000;
    localparam logic [2:0] T_KING   = 3'b001;
    localparam logic [2:0] T_QUEEN  = 3'b010;
    localparam logic [2:0] T_BISHOP = 3'b011;
    localparam logic [2:0] T_KNIGHT = 3'b100;
    localparam logic [2:0] T_ROOK   = 3'b101;
    localparam logic [2:0] T_PAWN   = 3'b110;
    localparam logic [2:0] T_NONE   = 3'b111;

    // Directions 0..3 are orthogonal (rook-like), 4..7 diagonal (bishop-like).
    localparam int DR [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
    localparam int DF [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
    localparam int NR [8] = '{1, 1, -1, -1, 2, 2, -2, -2};
    localparam int NF [8] = '{2, -2, 2, -2, 1, -1, 1, -1};

    logic [3:0] sq [64];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_unpack
            assign sq[gi] = bigBoard[4*gi +: 4];
        end
    endgenerate

    logic [3:0] home_code;
    logic [3:0] code;
    logic       def_color;
    logic       home_empty;
    logic       blocked;
    logic       attacked;
    logic       attack_next;
    int         rank;
    int         file;
    int         rr;
    int         ff;

    always_comb begin
        home_code   = sq[currentPosition];
        def_color   = home_code[3];
        home_empty  = (home_code[2:0] == T_EMPTY) || (home_code[2:0] == T_NONE);
        rank        = int'(currentPosition[5:3]);
        file        = int'(currentPosition[2:0]);
        attacked    = 1'b0;
        blocked     = 1'b0;
        code        = 4'b0000;
        rr          = 0;
        ff          = 0;

        // Sliding pieces: only the first occupied square on each ray matters.
        for (int d = 0; d < 8; d++) begin
            blocked = 1'b0;
            for (int s = 1; s < 8; s++) begin
                rr = rank + DR[d] * s;
                ff = file + DF[d] * s;
                if (!blocked && rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
                    code = sq[6'(rr * 8 + ff)];
                    if (code[2:0] != T_EMPTY && code[2:0] != T_NONE) begin
                        blocked = 1'b1;
                        if (code[3] != def_color &&
                            (code[2:0] == T_QUEEN ||
                             (d < 4 && code[2:0] == T_ROOK) ||
                             (d >= 4 && code[2:0] == T_BISHOP)))
                            attacked = 1'b1;
                    end
                end
            end
        end

        for (int k = 0; k < 8; k++) begin
            rr = rank + NR[k];
            ff = file + NF[k];
            if (rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
                code = sq[6'(rr * 8 + ff)];
                if (code[3] != def_color && code[2:0] == T_KNIGHT)
                    attacked = 1'b1;
            end
            rr = rank + DR[k];
            ff = file + DF[k];
            if (rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
                code = sq[6'(rr * 8 + ff)];
                if (code[3] != def_color && code[2:0] == T_KING)
                    attacked = 1'b1;
            end
        end

`ifdef CHECK_CHECK_PAWN_ATTACK_EN
        // Pawns capture toward the defender: black pawns sit one rank above a white king.
        for (int p = 0; p < 2; p++) begin
            rr = def_color ? rank - 1 : rank + 1;
            ff = (p == 0) ? file - 1 : file + 1;
            if (rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
                code = sq[6'(rr * 8 + ff)];
                if (code[3] != def_color && code[2:0] == T_PAWN)
                    attacked = 1'b1;
            end
        end
`else
        if (T_PAWN == T_EMPTY)
            attacked = 1'b0;
`endif

        attack_next = attacked && !home_empty;
    end

    always_ff @(posedge clk) begin
        if (reset)
            inCheck <= 1'b0;
        else
            inCheck <= attack_next;
    end

endmodule

// File: tb/tb_check_check.sv
// Directed-vector bench for check_check; each transaction prints one line.
module tb_check_check;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] bigBoard;
    logic [5:0]   currentPosition;
    logic         inCheck;

    int total = 0;
    int bad   = 0;

`ifdef CHECK_CHECK_PAWN_ATTACK_EN
    localparam logic PAWN_EXP = 1'b1;
`else
    localparam logic PAWN_EXP = 1'b0;
`endif

    check_check dut (
        .clk             (clk),
        .reset           (reset),
        .bigBoard        (bigBoard),
        .currentPosition (currentPosition),
        .inCheck         (inCheck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: inCheck=%b expected=%b", tag, observed, expected);
        end else begin
            $display("ok   %s: inCheck=%b", tag, observed);
        end
    endtask

    task automatic put(input int n, input logic [3:0] c);
        bigBoard[4*n +: 4] = c;
    endtask

    task automatic clear_board();
        bigBoard = '0;
    endtask

    // Apply the current inputs for one edge and sample just after it.
    task automatic step(input string tag, input logic expected);
        @(posedge clk);
        #1;
        check(tag, inCheck, expected);
    endtask

    initial begin
        reset = 1'b1;
        currentPosition = 6'd38;
        clear_board();
        put(32, 4'b1101);
        put(38, 4'b0001);
        step("reset_attacked_board", 1'b0);
        step("reset_hold", 1'b0);

        reset = 1'b0;
        step("rook_rank_attack", 1'b1);

        put(32, 4'b0101);
        step("own_rook_no_attack", 1'b0);

        put(32, 4'b1101);
        put(35, 4'b0110);
        step("rook_blocked_by_pawn", 1'b0);

        clear_board();
        put(21, 4'b1100);
        put(38, 4'b0001);
        step("knight_attack", 1'b1);

        clear_board();
        put(7, 4'b1011);
        put(8, 4'b0001);
        currentPosition = 6'd8;
        step("bishop_no_wrap", 1'b0);

        clear_board();
        put(14, 4'b1100);
        put(8, 4'b0001);
        step("knight_no_wrap", 1'b0);

        clear_board();
        put(0, 4'b1010);
        put(63, 4'b0001);
        currentPosition = 6'd63;
        step("queen_long_diagonal", 1'b1);

        clear_board();
        put(32, 4'b1011);
        put(38, 4'b0001);
        currentPosition = 6'd38;
        step("bishop_not_on_rank", 1'b0);

        clear_board();
        put(39, 4'b1001);
        put(38, 4'b0001);
        step("adjacent_king", 1'b1);

        clear_board();
        put(32, 4'b0101);
        put(38, 4'b1001);
        step("black_defender_rook", 1'b1);

        clear_board();
        put(32, 4'b1101);
        step("empty_home_square", 1'b0);

        clear_board();
        put(47, 4'b1110);
        put(38, 4'b0001);
        step("black_pawn_attack", PAWN_EXP);

        clear_board();
        put(29, 4'b0110);
        put(38, 4'b1001);
        step("white_pawn_attack", PAWN_EXP);

        clear_board();
        put(29, 4'b1110);
        put(38, 4'b0001);
        step("pawn_wrong_direction", 1'b0);

        clear_board();
        put(47, 4'b1110);
        put(38, 4'b0001);
        put(30, 4'b1101);
        put(32, 4'b1101);
        step("rook_file_attack", 1'b1);

        reset = 1'b1;
        step("reset_midstream", 1'b0);
        reset = 1'b0;
        step("resume_after_reset", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/check_check.md
CHECK_CHECK -- requirements
Module: check_check

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port bigBoard, input, 256 bits: 64 squares × 4-bit piece codes; square n occupies bits [4n+3:4n].
REQ-004 SHALL have port currentPosition, input, 6 bits: square index of the king under test; rank = [5:3], file = [2:0], index = 8·rank + file.
REQ-005 SHALL have port inCheck, output, 1 bit, registered: 1 when the piece at currentPosition is attacked by any opposite-colour piece.

Function
REQ-006 SHALL decode the piece code as follows: bit 3 = colour (0 white, 1 black); bits [2:0] = type: 000 empty, 001 king, 010 queen, 011 bishop, 100 knight, 101 rook, 110 pawn, 111 treated as empty.
REQ-007 SHALL take the defender colour from bit 3 of the code at currentPosition; only pieces of the other colour are attackers.
REQ-008 SHALL hold inCheck at 0 if the square at currentPosition is empty (type 000 or 111); the type at that square is otherwise not checked.
REQ-009 SHALL detect rook or queen attacks along the rank and the file, scanning outward in 4 directions and stopping at the first occupied square.
REQ-010 SHALL detect bishop or queen attacks along the 4 diagonals, with the same first-occupied-square stop rule.
REQ-011 SHALL detect knight attacks on the 8 L-offsets (±1,±2)/(±2,±1) and king attacks on the 8 adjacent squares.
REQ-012 SHALL detect pawn attacks as follows when the pawn feature is enabled (REQ-019):
  - White defender: attacked by a black pawn at (rank+1, file±1).
  - Black defender: attacked by a white pawn at (rank−1, file±1).
REQ-013 SHALL discard any offset or ray step that leaves ranks or files 0..7; there SHALL be no wrap-around between files 7 and 0 or past rank boundaries.
REQ-014 SHALL never let a same-colour piece attack; it only blocks rays.
REQ-015 SHALL compute the attack logic combinationally from the current inputs.
REQ-016 SHALL register inCheck on each rising clk edge, giving 1-cycle latency from an input change to the output.
REQ-017 SHALL give full weight to inputs that change mid-stream: every cycle is evaluated independently, with no history kept.

Reset
REQ-018 SHALL set inCheck to 0 on the first rising clk edge at which reset=1, and hold it at 0 while reset=1; reset SHALL take priority over evaluation, and evaluation SHALL resume on the first edge with reset=0.

Configuration
REQ-019 SHALL gate pawn detection with macro CHECK_CHECK_PAWN_ATTACK_EN:
  - Defined: pawn attacks per REQ-012 are included.
  - Undefined: pawns are never attackers; they still block rays.

Verification
REQ-020 SHALL pass these directed scenarios:
  - Black rook 4'b1101 at square 32, white king 4'b0001 at 38, currentPosition=38, rest empty -> inCheck=1 one edge after reset deasserts.
  - Same board, square 32 changed to 4'b0101 (white rook) -> inCheck=0 on the next edge.
  - Black rook at 32, white king at 38, white pawn at 35 -> inCheck=0 (ray blocked).
  - Black knight 4'b1100 at 21, white king at 38 -> inCheck=1.
  - Black bishop at 7, white king at 8 (rank 0 file 7 vs rank 1 file 0, no wrap) -> inCheck=0.
  - Any attacked board with reset=1 -> inCheck=0 on the same edge.
  - Black pawn at 47, white king at 38:
    - CHECK_CHECK_PAWN_ATTACK_EN defined -> inCheck=1.
    - CHECK_CHECK_PAWN_ATTACK_EN undefined -> inCheck=0.
